// File: rtl/snn_deadlock_watchdog_ctrl.sv
// snn_deadlock_watchdog_ctrl: times HLS deadlock-monitor block flags, flags sources that stay
// blocked for cfg_thresh cycles, round-robin reports them on one valid/ready channel and can
// pulse a per-source soft reset after each accepted report.
// Optional build macro: SNN_WDOG_IRQ_EN adds a registered irq output (= |pending).
module snn_deadlock_watchdog_ctrl #(
   parameter int unsigned NUM_SRC        = 4,
   parameter int unsigned CNT_W          = 16,
   parameter int unsigned TS_W           = 32,
   parameter int unsigned RECOVER_CYCLES = 16,
   localparam int unsigned SRC_W         = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [NUM_SRC-1:0] block_in,
   input  logic               cfg_enable,
   input  logic [CNT_W-1:0]   cfg_thresh,
   input  logic               cfg_auto_recover,
   output logic               rpt_valid,
   input  logic               rpt_ready,
   output logic [SRC_W-1:0]   rpt_src,
   output logic [TS_W-1:0]    rpt_ts,
   output logic [NUM_SRC-1:0] recover_rst,
   output logic               busy
`ifdef SNN_WDOG_IRQ_EN
   ,
   output logic               irq
`endif
);

   localparam int unsigned RC_W = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;

   typedef enum logic [1:0] {StIdle, StReport, StRecover} state_e;

   state_e             state_q, state_d;
   logic [TS_W-1:0]    ts_q;
   logic [CNT_W-1:0]   cnt_q [NUM_SRC];
   logic [CNT_W-1:0]   cnt_d [NUM_SRC];
   logic [TS_W-1:0]    ts_cap_q [NUM_SRC];
   logic [TS_W-1:0]    ts_cap_d [NUM_SRC];
   logic [NUM_SRC-1:0] fired_q, fired_d, pend_q, pend_d, fire;
   logic [SRC_W-1:0]   rr_q, rr_d, src_q, src_d, pick;
   logic               pick_vld;
   logic               valid_q, valid_d;
   logic [TS_W-1:0]    rts_q, rts_d;
   logic [RC_W-1:0]    rc_q, rc_d;
   logic               hs;

   // Index arithmetic modulo NUM_SRC; inputs never exceed 2*NUM_SRC-1.
   function automatic logic [SRC_W-1:0] wrap_idx(input int unsigned v);
      return (v >= NUM_SRC) ? SRC_W'(v - NUM_SRC) : SRC_W'(v);
   endfunction

   assign hs        = (state_q == StReport) && valid_q && rpt_ready;
   assign rpt_valid = valid_q;
   assign rpt_src   = src_q;
   assign rpt_ts    = rts_q;
   assign busy      = (state_q != StIdle);

   // Soft-reset pulse follows the RECOVER state for the last reported source.
   always_comb begin
      recover_rst = '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         recover_rst[i] = (state_q == StRecover) && (src_q == SRC_W'(i));
      end
   end

   // Per-source persistence counters; one event per blocked episode.
   always_comb begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         cnt_d[i]    = cnt_q[i];
         fired_d[i]  = fired_q[i];
         ts_cap_d[i] = ts_cap_q[i];
         fire[i]     = 1'b0;
         if (!block_in[i] || !cfg_enable || (cfg_thresh == '0) || recover_rst[i]) begin
            cnt_d[i]   = '0;
            fired_d[i] = 1'b0;
         end else if (!fired_q[i]) begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
            if ((CNT_W+1)'(cnt_q[i]) + (CNT_W+1)'(1) >= (CNT_W+1)'(cfg_thresh)) begin
               fired_d[i]  = 1'b1;
               fire[i]     = 1'b1;
               ts_cap_d[i] = ts_q;
            end
         end
         // A new fire wins over the handshake clear of the same source.
         pend_d[i] = (pend_q[i] && !(hs && (src_q == SRC_W'(i)))) || fire[i];
      end
   end

   // Round-robin pick: first pending source at or above rr_q, wrapping.
   always_comb begin
      pick     = '0;
      pick_vld = 1'b0;
      for (int unsigned k = 0; k < NUM_SRC; k++) begin
         if (!pick_vld && pend_q[wrap_idx(32'(rr_q) + k)]) begin
            pick     = wrap_idx(32'(rr_q) + k);
            pick_vld = 1'b1;
         end
      end
   end

   // Report / recover sequencer next state.
   always_comb begin
      state_d = state_q;
      valid_d = valid_q;
      src_d   = src_q;
      rts_d   = rts_q;
      rr_d    = rr_q;
      rc_d    = rc_q;
      case (state_q)
         StIdle: begin
            if (pick_vld) begin
               valid_d = 1'b1;
               src_d   = pick;
               rts_d   = ts_cap_q[pick];
               state_d = StReport;
            end
         end
         StReport: begin
            if (hs) begin
               valid_d = 1'b0;
               rr_d    = wrap_idx(32'(src_q) + 32'd1);
               if (cfg_auto_recover) begin
                  rc_d    = '0;
                  state_d = StRecover;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         StRecover: begin
            if (rc_q == RC_W'(RECOVER_CYCLES - 1)) begin
               state_d = StIdle;
            end else begin
               rc_d = rc_q + RC_W'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= StIdle;
         ts_q    <= '0;
         fired_q <= '0;
         pend_q  <= '0;
         rr_q    <= '0;
         src_q   <= '0;
         valid_q <= 1'b0;
         rts_q   <= '0;
         rc_q    <= '0;
         for (int unsigned i = 0; i < NUM_SRC; i++) begin
            cnt_q[i]    <= '0;
            ts_cap_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         ts_q    <= ts_q + TS_W'(1);
         fired_q <= fired_d;
         pend_q  <= pend_d;
         rr_q    <= rr_d;
         src_q   <= src_d;
         valid_q <= valid_d;
         rts_q   <= rts_d;
         rc_q    <= rc_d;
         for (int unsigned i = 0; i < NUM_SRC; i++) begin
            cnt_q[i]    <= cnt_d[i];
            ts_cap_q[i] <= ts_cap_d[i];
         end
      end
   end

`ifdef SNN_WDOG_IRQ_EN
   // Interrupt level tracks the registered pending set.
   always_ff @(posedge clock) begin
      if (reset) irq <= 1'b0;
      else       irq <= |pend_d;
   end
`endif

endmodule

// File: tb/tb_snn_deadlock_watchdog_ctrl.sv
// Directed bench for snn_deadlock_watchdog_ctrl (NUM_SRC=4, CNT_W=16, TS_W=32, RECOVER_CYCLES=16).
module tb_snn_deadlock_watchdog_ctrl;

   logic        clock = 1'b0;
   logic        reset;
   logic [3:0]  block_in;
   logic        cfg_enable;
   logic [15:0] cfg_thresh;
   logic        cfg_auto_recover;
   logic        rpt_valid;
   logic        rpt_ready;
   logic [1:0]  rpt_src;
   logic [31:0] rpt_ts;
   logic [3:0]  recover_rst;
   logic        busy;
`ifdef SNN_WDOG_IRQ_EN
   logic        irq;
`endif

   int          n_chk  = 0;
   int          n_pass = 0;
   logic [31:0] tb_ts;
   logic [31:0] exp_ts;

   snn_deadlock_watchdog_ctrl dut (
      .clock            (clock),
      .reset            (reset),
      .block_in         (block_in),
      .cfg_enable       (cfg_enable),
      .cfg_thresh       (cfg_thresh),
      .cfg_auto_recover (cfg_auto_recover),
      .rpt_valid        (rpt_valid),
      .rpt_ready        (rpt_ready),
      .rpt_src          (rpt_src),
      .rpt_ts           (rpt_ts),
      .recover_rst      (recover_rst),
      .busy             (busy)
`ifdef SNN_WDOG_IRQ_EN
      ,
      .irq              (irq)
`endif
   );

   always #5 clock = ~clock;

   // Reference free-running timestamp.
   always @(posedge clock) begin
      if (reset) tb_ts <= '0;
      else       tb_ts <= tb_ts + 32'd1;
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   task automatic chk_irq(input string tag, input logic exp);
`ifdef SNN_WDOG_IRQ_EN
      chk(tag, 64'(irq), 64'(exp));
`endif
   endtask

   initial begin
      reset            = 1'b1;
      block_in         = '0;
      cfg_enable       = 1'b1;
      cfg_thresh       = 16'd4;
      cfg_auto_recover = 1'b0;
      rpt_ready        = 1'b0;
      step(2);
      chk("rst_valid", 64'(rpt_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_recover", 64'(recover_rst), 64'd0);
      chk("rst_src", 64'(rpt_src), 64'd0);
      chk("rst_ts", 64'(rpt_ts), 64'd0);
      chk_irq("rst_irq", 1'b0);
      reset = 1'b0;

      // Source 1 blocked for exactly the threshold.
      block_in = 4'b0010;
      step(3);
      exp_ts = tb_ts;
      step(1);
      chk("t1_valid_latency", 64'(rpt_valid), 64'd0);
      chk_irq("t1_irq_set", 1'b1);
      step(1);
      chk("t1_valid", 64'(rpt_valid), 64'd1);
      chk("t1_src", 64'(rpt_src), 64'd1);
      chk("t1_ts", 64'(rpt_ts), 64'(exp_ts));
      chk("t1_busy", 64'(busy), 64'd1);
      block_in  = '0;
      rpt_ready = 1'b1;
      step(1);
      chk("t1_hs_valid", 64'(rpt_valid), 64'd0);
      chk("t1_hs_busy", 64'(busy), 64'd0);
      chk_irq("t1_irq_clr", 1'b0);
      rpt_ready = 1'b0;
      step(3);
      chk("t1_no_refire", 64'(rpt_valid), 64'd0);

      // Source 2 blocked one cycle short, twice: counter must clear in between.
      block_in = 4'b0100;
      step(3);
      block_in = '0;
      step(1);
      chk("t2_short_valid", 64'(rpt_valid), 64'd0);
      block_in = 4'b0100;
      step(3);
      block_in = '0;
      step(3);
      chk("t2_cleared_valid", 64'(rpt_valid), 64'd0);
      chk("t2_cleared_busy", 64'(busy), 64'd0);

      // Sources 0 and 3 fire together; served 3 then 0.
      block_in = 4'b1001;
      step(3);
      exp_ts = tb_ts;
      step(1);
      block_in = '0;
      step(1);
      chk("t3_first_valid", 64'(rpt_valid), 64'd1);
      chk("t3_first_src", 64'(rpt_src), 64'd3);
      chk("t3_first_ts", 64'(rpt_ts), 64'(exp_ts));
      rpt_ready = 1'b1;
      step(1);
      chk("t3_gap_valid", 64'(rpt_valid), 64'd0);
      chk_irq("t3_irq_still", 1'b1);
      step(1);
      chk("t3_second_valid", 64'(rpt_valid), 64'd1);
      chk("t3_second_src", 64'(rpt_src), 64'd0);
      chk("t3_second_ts", 64'(rpt_ts), 64'(exp_ts));
      step(1);
      chk("t3_done_valid", 64'(rpt_valid), 64'd0);
      chk_irq("t3_irq_clr", 1'b0);
      rpt_ready = 1'b0;

      // Auto-recover on source 2: 16-cycle one-hot pulse.
      cfg_auto_recover = 1'b1;
      block_in = 4'b0100;
      step(4);
      block_in = '0;
      step(1);
      chk("t4_valid", 64'(rpt_valid), 64'd1);
      chk("t4_src", 64'(rpt_src), 64'd2);
      rpt_ready = 1'b1;
      step(1);
      rpt_ready = 1'b0;
      chk("t4_rec_first", 64'(recover_rst), 64'b0100);
      chk("t4_rec_busy", 64'(busy), 64'd1);
      chk("t4_rec_valid", 64'(rpt_valid), 64'd0);
      for (int i = 0; i < 15; i++) begin
         step(1);
         chk("t4_rec_hold", 64'(recover_rst), 64'b0100);
      end
      step(1);
      chk("t4_rec_end", 64'(recover_rst), 64'd0);
      chk("t4_idle", 64'(busy), 64'd0);
      cfg_auto_recover = 1'b0;

      // Threshold lowered below the running count fires on the next counted cycle.
      cfg_thresh = 16'd10;
      block_in   = 4'b1000;
      step(5);
      cfg_thresh = 16'd3;
      exp_ts     = tb_ts;
      step(1);
      chk("t5_lower_lat", 64'(rpt_valid), 64'd0);
      step(1);
      chk("t5_lower_valid", 64'(rpt_valid), 64'd1);
      chk("t5_lower_src", 64'(rpt_src), 64'd3);
      chk("t5_lower_ts", 64'(rpt_ts), 64'(exp_ts));
      rpt_ready = 1'b1;
      step(1);
      rpt_ready = 1'b0;
      block_in  = '0;
      cfg_thresh = 16'd4;
      chk("t5_lower_hs", 64'(rpt_valid), 64'd0);

      // Threshold 0 disables the watchdog.
      cfg_thresh = 16'd0;
      block_in   = 4'b0001;
      step(8);
      chk("t6_thr0_valid", 64'(rpt_valid), 64'd0);
      chk("t6_thr0_busy", 64'(busy), 64'd0);
      block_in = '0;
      step(1);
      cfg_thresh = 16'd4;

      // Report held with no ready while source stays blocked.
      block_in = 4'b0010;
      step(3);
      exp_ts = tb_ts;
      step(2);
      for (int i = 0; i < 20; i++) begin
         chk("t7_hold_valid", 64'(rpt_valid), 64'd1);
         chk("t7_hold_src", 64'(rpt_src), 64'd1);
         chk("t7_hold_ts", 64'(rpt_ts), 64'(exp_ts));
         step(1);
      end
      rpt_ready = 1'b1;
      step(1);
      rpt_ready = 1'b0;
      chk("t7_hs_valid", 64'(rpt_valid), 64'd0);
      step(5);
      chk("t7_no_refire", 64'(rpt_valid), 64'd0);
      chk("t7_no_refire_busy", 64'(busy), 64'd0);
      block_in = '0;

      // Reset in the middle of a recover pulse.
      cfg_auto_recover = 1'b1;
      block_in = 4'b0001;
      step(4);
      block_in = '0;
      step(1);
      chk("t8_valid", 64'(rpt_valid), 64'd1);
      chk("t8_src", 64'(rpt_src), 64'd0);
      rpt_ready = 1'b1;
      step(1);
      rpt_ready = 1'b0;
      chk("t8_rec", 64'(recover_rst), 64'b0001);
      step(4);
      chk("t8_rec_mid", 64'(recover_rst), 64'b0001);
      reset = 1'b1;
      step(1);
      chk("t8_rst_recover", 64'(recover_rst), 64'd0);
      chk("t8_rst_valid", 64'(rpt_valid), 64'd0);
      chk("t8_rst_busy", 64'(busy), 64'd0);
      chk("t8_rst_src", 64'(rpt_src), 64'd0);
      chk_irq("t8_rst_irq", 1'b0);
      reset = 1'b0;
      step(2);
      chk("t8_after_valid", 64'(rpt_valid), 64'd0);
      chk("t8_after_busy", 64'(busy), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
